// File: rtl/duckhunt_pkg.sv
// Shared constants and types for the Duck Hunt VGA datapath.
// The screen geometry matches the 160x120 vga_adapter mode.
package duckhunt_pkg;

    localparam int NUM_REQ  = 3;
    localparam int X_W      = 8;
    localparam int Y_W      = 7;
    localparam int COLOUR_W = 24;
    localparam int SIZE_W   = 5;
    localparam int SCREEN_W = 160;
    localparam int SCREEN_H = 120;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DRAW = 2'd1,
        DONE = 2'd2
    } arb_state_t;

endpackage

// File: rtl/vga_plot_arbiter_rr_pick.sv
// Combinational round-robin picker: returns the first valid requester
// at or after ptr, wrapping past the highest index back to zero.
module rr_pick #(
    parameter int NUM_REQ = duckhunt_pkg::NUM_REQ,
    parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] valid,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] onehot,
    output logic [IDX_W-1:0]   index,
    output logic               any
);

    int             cand;
    logic [IDX_W-1:0] cand_idx;

    // Walk the requesters starting at ptr; the first valid one wins.
    always_comb begin
        onehot   = '0;
        index    = '0;
        any      = 1'b0;
        cand     = 0;
        cand_idx = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = int'(ptr) + k;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            cand_idx = IDX_W'(cand);
            if (!any && valid[cand_idx]) begin
                any              = 1'b1;
                index            = cand_idx;
                onehot[cand_idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/vga_plot_arbiter.sv
// Round-robin owner of the vga_adapter plot port: grants one sprite drawer
// at a time and scans its solid rectangle one pixel per clock.
module vga_plot_arbiter #(
    parameter int NUM_REQ  = duckhunt_pkg::NUM_REQ,
    parameter int X_W      = duckhunt_pkg::X_W,
    parameter int Y_W      = duckhunt_pkg::Y_W,
    parameter int COLOUR_W = duckhunt_pkg::COLOUR_W,
    parameter int SIZE_W   = duckhunt_pkg::SIZE_W,
    parameter int SCREEN_W = duckhunt_pkg::SCREEN_W,
    parameter int SCREEN_H = duckhunt_pkg::SCREEN_H
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_REQ-1:0]           req_valid,
    input  logic [NUM_REQ*X_W-1:0]       req_x,
    input  logic [NUM_REQ*Y_W-1:0]       req_y,
    input  logic [NUM_REQ*SIZE_W-1:0]    req_w,
    input  logic [NUM_REQ*SIZE_W-1:0]    req_h,
    input  logic [NUM_REQ*COLOUR_W-1:0]  req_colour,
    input  logic                         hold,
    output logic [NUM_REQ-1:0]           req_grant,
    output logic [NUM_REQ-1:0]           req_done,
    output logic                         busy,
    output logic [X_W-1:0]               x,
    output logic [Y_W-1:0]               y,
    output logic [COLOUR_W-1:0]          colour,
    output logic                         plot
);

    import duckhunt_pkg::*;

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    // Extra carry bit: a coordinate past the right/bottom edge is clipped, never wrapped.
    function automatic logic on_screen(input logic [X_W:0] sx, input logic [Y_W:0] sy);
        return (sx < (X_W+1)'(SCREEN_W)) && (sy < (Y_W+1)'(SCREEN_H));
    endfunction

    arb_state_t            state, state_n;
    logic [IDX_W-1:0]      ptr, ptr_n;
    logic [IDX_W-1:0]      owner, owner_n;
    logic [X_W-1:0]        rect_x, rect_x_n;
    logic [Y_W-1:0]        rect_y, rect_y_n;
    logic [SIZE_W-1:0]     rect_w, rect_w_n;
    logic [SIZE_W-1:0]     rect_h, rect_h_n;
    logic [SIZE_W-1:0]     col, col_n;
    logic [SIZE_W-1:0]     row, row_n;
    logic [NUM_REQ-1:0]    req_grant_n, req_done_n;
    logic                  busy_n, plot_n;
    logic [X_W-1:0]        x_n;
    logic [Y_W-1:0]        y_n;
    logic [COLOUR_W-1:0]   colour_n;

    logic [NUM_REQ-1:0]    pick_onehot;
    logic [IDX_W-1:0]      pick_idx;
    logic                  pick_any;

    logic [X_W-1:0]        sel_x;
    logic [Y_W-1:0]        sel_y;
    logic [SIZE_W-1:0]     sel_w, sel_h;
    logic [COLOUR_W-1:0]   sel_colour;

    logic                  col_wrap, last_pixel;
    logic [SIZE_W-1:0]     adv_col, adv_row;
    logic [X_W:0]          scan_x;
    logic [Y_W:0]          scan_y;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_pick (
        .valid  (req_valid),
        .ptr    (ptr),
        .onehot (pick_onehot),
        .index  (pick_idx),
        .any    (pick_any)
    );

    always_comb begin
        sel_x      = '0;
        sel_y      = '0;
        sel_w      = '0;
        sel_h      = '0;
        sel_colour = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pick_onehot[i]) begin
                sel_x      = req_x[i*X_W +: X_W];
                sel_y      = req_y[i*Y_W +: Y_W];
                sel_w      = req_w[i*SIZE_W +: SIZE_W];
                sel_h      = req_h[i*SIZE_W +: SIZE_W];
                sel_colour = req_colour[i*COLOUR_W +: COLOUR_W];
            end
        end
    end

    // Row-major scan position of the pixel that follows the one on the port now.
    always_comb begin
        col_wrap   = (col == rect_w - SIZE_W'(1));
        last_pixel = col_wrap && (row == rect_h - SIZE_W'(1));
        adv_col    = col_wrap ? '0 : col + SIZE_W'(1);
        adv_row    = col_wrap ? row + SIZE_W'(1) : row;
        scan_x     = {1'b0, rect_x} + (X_W+1)'(adv_col);
        scan_y     = {1'b0, rect_y} + (Y_W+1)'(adv_row);
    end

    always_comb begin
        state_n     = state;
        ptr_n       = ptr;
        owner_n     = owner;
        rect_x_n    = rect_x;
        rect_y_n    = rect_y;
        rect_w_n    = rect_w;
        rect_h_n    = rect_h;
        col_n       = col;
        row_n       = row;
        req_grant_n = req_grant;
        req_done_n  = '0;
        busy_n      = busy;
        x_n         = x;
        y_n         = y;
        colour_n    = colour;
        plot_n      = 1'b0;

        case (state)
            IDLE: begin
                busy_n      = 1'b0;
                req_grant_n = '0;
                if (pick_any && !hold) begin
                    req_grant_n = pick_onehot;
                    owner_n     = pick_idx;
                    rect_x_n    = sel_x;
                    rect_y_n    = sel_y;
                    rect_w_n    = sel_w;
                    rect_h_n    = sel_h;
                    col_n       = '0;
                    row_n       = '0;
                    busy_n      = 1'b1;
                    x_n         = sel_x;
                    y_n         = sel_y;
                    colour_n    = sel_colour;
                    if (sel_w == '0 || sel_h == '0) begin
                        state_n    = DONE;
                        req_done_n = pick_onehot;
                    end else begin
                        state_n = DRAW;
                        plot_n  = on_screen({1'b0, sel_x}, {1'b0, sel_y});
                    end
                end
            end

            DRAW: begin
                if (!hold) begin
                    if (last_pixel) begin
                        state_n    = DONE;
                        req_done_n = req_grant;
                    end else begin
                        col_n  = adv_col;
                        row_n  = adv_row;
                        x_n    = scan_x[X_W-1:0];
                        y_n    = scan_y[Y_W-1:0];
                        plot_n = on_screen(scan_x, scan_y);
                    end
                end
            end

            DONE: begin
                state_n     = IDLE;
                req_grant_n = '0;
                busy_n      = 1'b0;
                ptr_n       = (owner == IDX_W'(NUM_REQ-1)) ? '0 : owner + IDX_W'(1);
            end

            default: begin
                state_n     = IDLE;
                req_grant_n = '0;
                busy_n      = 1'b0;
            end
        endcase
    end

    // Reset abandons any transaction in flight without a done pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            ptr       <= '0;
            owner     <= '0;
            rect_x    <= '0;
            rect_y    <= '0;
            rect_w    <= '0;
            rect_h    <= '0;
            col       <= '0;
            row       <= '0;
            req_grant <= '0;
            req_done  <= '0;
            busy      <= 1'b0;
            x         <= '0;
            y         <= '0;
            colour    <= '0;
            plot      <= 1'b0;
        end else begin
            state     <= state_n;
            ptr       <= ptr_n;
            owner     <= owner_n;
            rect_x    <= rect_x_n;
            rect_y    <= rect_y_n;
            rect_w    <= rect_w_n;
            rect_h    <= rect_h_n;
            col       <= col_n;
            row       <= row_n;
            req_grant <= req_grant_n;
            req_done  <= req_done_n;
            busy      <= busy_n;
            x         <= x_n;
            y         <= y_n;
            colour    <= colour_n;
            plot      <= plot_n;
        end
    end

endmodule

// File: tb/tb_vga_plot_arbiter.sv
// Directed bench for vga_plot_arbiter: single fill, round-robin order,
// clipping, empty rectangle, hold and reset-in-flight.
module tb_vga_plot_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  req_valid;
    logic [23:0] req_x;
    logic [20:0] req_y;
    logic [14:0] req_w;
    logic [14:0] req_h;
    logic [71:0] req_colour;
    logic        hold;
    logic [2:0]  req_grant;
    logic [2:0]  req_done;
    logic        busy;
    logic [7:0]  x;
    logic [6:0]  y;
    logic [23:0] colour;
    logic        plot;

    int checks = 0;
    int errors = 0;

    vga_plot_arbiter dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_x      (req_x),
        .req_y      (req_y),
        .req_w      (req_w),
        .req_h      (req_h),
        .req_colour (req_colour),
        .hold       (hold),
        .req_grant  (req_grant),
        .req_done   (req_done),
        .busy       (busy),
        .x          (x),
        .y          (y),
        .colour     (colour),
        .plot       (plot)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic apply_stimulus(input int i, input logic [7:0] rx, input logic [6:0] ry,
                                  input logic [4:0] rw, input logic [4:0] rh, input logic [23:0] rc);
        req_x[i*8 +: 8]       = rx;
        req_y[i*7 +: 7]       = ry;
        req_w[i*5 +: 5]       = rw;
        req_h[i*5 +: 5]       = rh;
        req_colour[i*24 +: 24] = rc;
        req_valid[i]          = 1'b1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    logic [7:0]  t1x [4] = '{8'd10, 8'd11, 8'd10, 8'd11};
    logic [6:0]  t1y [4] = '{7'd20, 7'd20, 7'd21, 7'd21};
    logic [7:0]  t3x [4] = '{8'd158, 8'd159, 8'd158, 8'd159};
    logic [6:0]  t3y [4] = '{7'd118, 7'd118, 7'd119, 7'd119};
    logic [2:0]  order [4];
    int          n;
    int          np;
    int          done_cyc;

    initial begin
        reset      = 1'b1;
        req_valid  = '0;
        req_x      = '0;
        req_y      = '0;
        req_w      = '0;
        req_h      = '0;
        req_colour = '0;
        hold       = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_output("rst_plot",  {63'd0, plot}, 64'd0);
        check_output("rst_busy",  {63'd0, busy}, 64'd0);
        check_output("rst_grant", {61'd0, req_grant}, 64'd0);
        check_output("rst_done",  {61'd0, req_done}, 64'd0);
        check_output("rst_xyc",   {25'd0, x, y, colour}, 64'd0);
        reset = 1'b0;
        @(negedge clk);

        // Single 2x2 fill from requester 0
        apply_stimulus(0, 8'd10, 7'd20, 5'd2, 5'd2, 24'hFF0000);
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            check_output($sformatf("t1_pix%0d", c), {48'd0, plot, x, y}, {48'd0, 1'b1, t1x[c-1], t1y[c-1]});
            if (c == 1) begin
                check_output("t1_grant",  {61'd0, req_grant}, 64'd1);
                check_output("t1_colour", {40'd0, colour}, 64'hFF0000);
            end
        end
        @(negedge clk);
        check_output("t1_done",      {61'd0, req_done}, 64'd1);
        check_output("t1_done_plot", {63'd0, plot}, 64'd0);
        req_valid[0] = 1'b0;
        @(negedge clk);
        check_output("t1_idle_done", {61'd0, req_done}, 64'd0);
        check_output("t1_idle_busy", {63'd0, busy}, 64'd0);

        // Round-robin between two continuously valid requesters
        do_reset();
        apply_stimulus(0, 8'd0, 7'd0, 5'd1, 5'd1, 24'h00FF00);
        apply_stimulus(1, 8'd5, 7'd5, 5'd1, 5'd1, 24'h0000FF);
        n = 0;
        for (int c = 0; c < 40 && n < 4; c++) begin
            @(negedge clk);
            if (req_done != 3'b000) begin
                order[n] = req_done;
                n++;
            end
        end
        req_valid = '0;
        check_output("t2_count", 64'(n), 64'd4);
        check_output("t2_ord0", {61'd0, order[0]}, 64'd1);
        check_output("t2_ord1", {61'd0, order[1]}, 64'd2);
        check_output("t2_ord2", {61'd0, order[2]}, 64'd1);
        check_output("t2_ord3", {61'd0, order[3]}, 64'd2);
        @(negedge clk);
        @(negedge clk);

        // Clipping at the bottom-right corner
        apply_stimulus(2, 8'd158, 7'd118, 5'd4, 5'd4, 24'h123456);
        np = 0;
        done_cyc = 0;
        for (int c = 1; c <= 40 && done_cyc == 0; c++) begin
            @(negedge clk);
            if (plot) begin
                if (np < 4)
                    check_output($sformatf("t3_pix%0d", np), {49'd0, x, y}, {49'd0, t3x[np], t3y[np]});
                else
                    check_output("t3_extra_plot", 64'd1, 64'd0);
                np++;
            end
            if (req_done != 3'b000) begin
                done_cyc = c;
                check_output("t3_done_who", {61'd0, req_done}, 64'd4);
                req_valid[2] = 1'b0;
            end
        end
        check_output("t3_plots",    64'(np), 64'd4);
        check_output("t3_done_cyc", 64'(done_cyc), 64'd17);
        @(negedge clk);

        // Empty rectangle: done the cycle after grant, no plot
        apply_stimulus(1, 8'd40, 7'd40, 5'd0, 5'd3, 24'hABCDEF);
        @(negedge clk);
        check_output("t4_done", {61'd0, req_done}, 64'd2);
        check_output("t4_plot", {63'd0, plot}, 64'd0);
        req_valid[1] = 1'b0;
        @(negedge clk);
        check_output("t4_done_clear", {61'd0, req_done}, 64'd0);
        check_output("t4_busy_clear", {63'd0, busy}, 64'd0);

        // Hold for three cycles on a 3x1 rectangle
        apply_stimulus(0, 8'd20, 7'd30, 5'd3, 5'd1, 24'h777777);
        @(negedge clk);
        check_output("t5_pix0", {48'd0, plot, x, y}, {48'd0, 1'b1, 8'd20, 7'd30});
        hold = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check_output($sformatf("t5_hold%0d", c), {48'd0, plot, x, y}, {48'd0, 1'b0, 8'd20, 7'd30});
        end
        hold = 1'b0;
        @(negedge clk);
        check_output("t5_pix1", {48'd0, plot, x, y}, {48'd0, 1'b1, 8'd21, 7'd30});
        @(negedge clk);
        check_output("t5_pix2", {48'd0, plot, x, y}, {48'd0, 1'b1, 8'd22, 7'd30});
        @(negedge clk);
        check_output("t5_done", {61'd0, req_done}, 64'd1);
        check_output("t5_done_plot", {63'd0, plot}, 64'd0);
        req_valid[0] = 1'b0;
        @(negedge clk);

        // Reset during DRAW, then arbitration restarts from requester 0
        apply_stimulus(2, 8'd10, 7'd10, 5'd4, 5'd4, 24'h555555);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        check_output("t6_drawing", {63'd0, busy}, 64'd1);
        #2 reset = 1'b1;
        #1;
        check_output("t6_async_plot",  {63'd0, plot}, 64'd0);
        check_output("t6_async_busy",  {63'd0, busy}, 64'd0);
        check_output("t6_async_grant", {61'd0, req_grant}, 64'd0);
        check_output("t6_async_xy",    {49'd0, x, y}, 64'd0);
        req_valid = '0;
        @(negedge clk);
        check_output("t6_no_done_a", {61'd0, req_done}, 64'd0);
        reset = 1'b0;
        @(negedge clk);
        check_output("t6_no_done_b", {61'd0, req_done}, 64'd0);
        apply_stimulus(0, 8'd1, 7'd1, 5'd1, 5'd1, 24'h111111);
        apply_stimulus(2, 8'd2, 7'd2, 5'd1, 5'd1, 24'h222222);
        @(negedge clk);
        check_output("t6_grant_r0", {61'd0, req_grant}, 64'd1);
        check_output("t6_pix",      {48'd0, plot, x, y}, {48'd0, 1'b1, 8'd1, 7'd1});
        req_valid = '0;
        @(negedge clk);
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
